// File: rtl/axis_frame_packetizer_if.sv
// Stream bundle for the frame packetizer: unframed input beats in,
// framed (tlast/tuser) beats out, plus frame length and timeout pulse.
interface axis_frame_packetizer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] input_axis_tdata;
  logic                  input_axis_tvalid;
  logic                  input_axis_tready;
  logic [LEN_WIDTH-1:0]  frame_len;
  logic [DATA_WIDTH-1:0] output_axis_tdata;
  logic                  output_axis_tvalid;
  logic                  output_axis_tready;
  logic                  output_axis_tlast;
  logic                  output_axis_tuser;
  logic                  frame_timeout;

  modport slave (
    input  input_axis_tdata, input_axis_tvalid, frame_len, output_axis_tready,
    output input_axis_tready, output_axis_tdata, output_axis_tvalid,
    output_axis_tlast, output_axis_tuser, frame_timeout
  );

  modport master (
    output input_axis_tdata, input_axis_tvalid, frame_len, output_axis_tready,
    input  input_axis_tready, output_axis_tdata, output_axis_tvalid,
    output_axis_tlast, output_axis_tuser, frame_timeout
  );
endinterface

// File: rtl/axis_frame_packetizer.sv
// Frames an unframed beat stream: tlast every frame_len beats, or early
// (with tuser=1) when the source goes idle mid-frame for TIMEOUT cycles.
module axis_frame_packetizer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_frame_packetizer_if.slave bus
);
  localparam int IW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  user;
  } beat_t;

  beat_t                h, o;
  logic [LEN_WIDTH-1:0] beat_cnt, len_reg, len_eff;
  logic [IW-1:0]        idle_cnt;
  logic                 o_free, accept, xfer, new_last, tmo, timeout_q;

  always_comb begin
    o_free   = ~o.valid | bus.output_axis_tready;
    accept   = bus.input_axis_tvalid & (~h.valid | o_free);
    // Length is latched on the first beat of a frame; zero is treated as one.
    len_eff  = (beat_cnt != '0) ? len_reg :
               (bus.frame_len == '0) ? LEN_WIDTH'(1) : bus.frame_len;
    new_last = (beat_cnt == len_eff - LEN_WIDTH'(1));
    // A non-last H must wait for its successor: tlast may still land on it.
    xfer     = h.valid & o_free & (h.last | accept);
    tmo      = (TIMEOUT != 0) && h.valid && !h.last && !accept &&
               (idle_cnt == IW'(TMAX));
  end

  assign bus.input_axis_tready  = ~h.valid | o_free;
  assign bus.output_axis_tdata  = o.data;
  assign bus.output_axis_tvalid = o.valid;
  assign bus.output_axis_tlast  = o.last;
  assign bus.output_axis_tuser  = o.user;
  assign bus.frame_timeout      = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h         <= '0;
      o         <= '0;
      beat_cnt  <= '0;
      len_reg   <= '0;
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (xfer)
        o <= h;
      else if (o.valid & bus.output_axis_tready)
        o.valid <= 1'b0;

      if (accept) begin
        h        <= '{valid: 1'b1, data: bus.input_axis_tdata, last: new_last, user: 1'b0};
        len_reg  <= len_eff;
        beat_cnt <= new_last ? '0 : beat_cnt + LEN_WIDTH'(1);
        idle_cnt <= '0;
      end else if (xfer) begin
        h <= '0;
      end else if (tmo) begin
        // Close the partial frame on the held beat and mark it bad.
        h.last    <= 1'b1;
        h.user    <= 1'b1;
        beat_cnt  <= '0;
        idle_cnt  <= '0;
        timeout_q <= 1'b1;
      end else if (TIMEOUT != 0 && h.valid && !h.last) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end
endmodule
